// File: rtl/vector_divide_pkg.sv
// Shared definitions for the vector divide block: loader FSM encoding and the
// default sizing parameters used by the loader and the divider it feeds.
package vector_divide_pkg;

    localparam int DEF_RAM_SIZE = 10;   // 1024-word operand RAM
    localparam int DEF_NBITS    = 32;
    localparam int DEF_MAXN     = 256;  // must not exceed 2**(RAM_SIZE-1)

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } vl_state_e;

    // The loader takes operand words only while it is between vectors or mid-vector.
    function automatic logic accepts_words(input vl_state_e s);
        return (s == IDLE) || (s == LOAD);
    endfunction

endpackage

// File: rtl/vector_loader.sv
// Streams X/Y operand pairs into the divider RAM, then starts the vector divider
// with the pair count and waits for it to finish.
module vector_loader
    import vector_divide_pkg::*;
#(
    parameter int RAM_SIZE = DEF_RAM_SIZE,
    parameter int NBITS    = DEF_NBITS,
    parameter int MAXN     = DEF_MAXN
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NBITS-1:0]    in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic [RAM_SIZE-1:0] Addr,
    output logic [NBITS-1:0]    Wdata,
    output logic                Wenable,
    output logic [RAM_SIZE-1:0] Ndata,
    output logic                startvd,
    input  logic                busyvd,
    output logic                done,
    output logic                err
);

    localparam logic [RAM_SIZE-1:0] MAXN_CNT = RAM_SIZE'(MAXN);
    localparam logic [RAM_SIZE-1:0] ONE      = RAM_SIZE'(1);

    vl_state_e           state_q,    state_d;
    logic [RAM_SIZE-1:0] word_cnt_q, word_cnt_d;
    logic [RAM_SIZE-1:0] pair_cnt_q, pair_cnt_d;
    logic [RAM_SIZE-1:0] addr_q,     addr_d;
    logic [NBITS-1:0]    wdata_q,    wdata_d;
    logic [RAM_SIZE-1:0] ndata_q,    ndata_d;
    logic                wenable_q,  wenable_d;
    logic                startvd_q,  startvd_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                in_ready_q, in_ready_d;

    logic                accept;
    logic                is_y;
    logic [RAM_SIZE-1:0] word_idx;
    logic [RAM_SIZE-1:0] pair_base;
    logic [RAM_SIZE-1:0] pair_next;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves a latch.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pair_cnt_d = pair_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ndata_d    = ndata_q;
        err_d      = err_q;
        wenable_d  = 1'b0;

        // The first word of a vector restarts counting from zero.
        word_idx  = (state_q == IDLE) ? '0 : word_cnt_q;
        pair_base = (state_q == IDLE) ? '0 : pair_cnt_q;
        pair_next = pair_base + ONE;
        is_y      = word_idx[0];

        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    word_cnt_d = word_idx + ONE;
                    addr_d     = word_idx;
                    wdata_d    = in_data;
                    wenable_d  = 1'b1;
                    pair_cnt_d = is_y ? pair_next : pair_base;
                    if (state_q == IDLE) begin
                        err_d   = 1'b0;
                        ndata_d = '0;
                    end
                    if (in_last) begin
                        if (is_y) begin
                            state_d = KICK;
                        end else begin
                            // Unpaired trailing X is written but never counted.
                            err_d   = 1'b1;
                            state_d = (pair_base != '0) ? KICK : FINISH;
                        end
                    end else if (is_y && (pair_next == MAXN_CNT)) begin
                        err_d   = 1'b1;
                        state_d = KICK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            KICK:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (busyvd)  state_d = WAIT_DONE;
            WAIT_DONE: if (!busyvd) state_d = FINISH;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state they belong to.
        if (state_d == KICK) begin
            ndata_d = pair_cnt_d;
        end
        startvd_d  = (state_d == KICK);
        done_d     = (state_d == FINISH);
        in_ready_d = accepts_words(state_d);
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
        if (!reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            pair_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ndata_q    <= '0;
            wenable_q  <= 1'b0;
            startvd_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ndata_q    <= ndata_d;
            wenable_q  <= wenable_d;
            startvd_q  <= startvd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign Addr     = addr_q;
    assign Wdata    = wdata_q;
    assign Wenable  = wenable_q;
    assign Ndata    = ndata_q;
    assign startvd  = startvd_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader with MAXN=4: normal, stalled, odd-count,
// single-word, overflow and mid-wait reset vectors, checked by immediate assertions.
module tb_vector_loader;

    localparam int RS = 10;
    localparam int NB = 32;
    localparam int MX = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [NB-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [RS-1:0] Addr;
    logic [NB-1:0] Wdata;
    logic          Wenable;
    logic [RS-1:0] Ndata;
    logic          startvd;
    logic          busyvd;
    logic          done;
    logic          err;

    vector_loader #(.RAM_SIZE(RS), .NBITS(NB), .MAXN(MX)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .Addr     (Addr),
        .Wdata    (Wdata),
        .Wenable  (Wenable),
        .Ndata    (Ndata),
        .startvd  (startvd),
        .busyvd   (busyvd),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Write / pulse monitor, sampled on the falling edge.
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          nwr     = 0;
    int          bad_wen = 0;
    int          n_start = 0;
    int          n_done  = 0;
    logic        acc_prev = 1'b0;

    always @(negedge clock) begin
        if (Wenable) begin
            if (nwr < 64) begin
                wr_addr[nwr] <= 32'(Addr);
                wr_data[nwr] <= Wdata;
            end
            nwr <= nwr + 1;
            if (!acc_prev) bad_wen <= bad_wen + 1;
        end
        acc_prev <= in_valid && in_ready;
        if (startvd) n_start <= n_start + 1;
        if (done)    n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one word after `gap` idle cycles and holds it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic last, input int gap, output logic ok);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Plays the divider: busy for 10 cycles, then waits a bounded time for done.
    task automatic run_divider(output logic ok);
        busyvd = 1'b1;
        repeat (10) tick();
        busyvd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clock);
            ok = done;
            tick();
        end
    endtask

    task automatic check_writes(input string tag, input int base, input int n, input logic [31:0] a0,
                                input logic [31:0] exp_data [6]);
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, wr_addr[base+i], a0 + 32'(i));
            check({tag, "_data"}, wr_data[base+i], exp_data[i]);
        end
    endtask

    logic [31:0] v1 [6] = '{100, 5, 81, 9, 7, 2};
    logic [31:0] v3 [6] = '{10, 2, 20, 4, 30, 0};
    logic [31:0] v6 [6] = '{6, 2, 0, 0, 0, 0};
    logic        ok;
    int          base;
    int          s0;
    int          d0;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        busyvd   = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_wenable",  Wenable,  0);
        check("rst_startvd",  startvd,  0);
        check("rst_done",     done,     0);
        check("rst_err",      err,      0);
        check("rst_addr",     Addr,     0);
        check("rst_wdata",    Wdata,    0);
        check("rst_ndata",    Ndata,    0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("ready_before_edge", in_ready, 0);
        tick();
        @(negedge clock);
        check("ready_after_release", in_ready, 1);
        tick();

        // Three pairs, no stalls
        base = nwr; s0 = n_start; d0 = n_done;
        for (int i = 0; i < 6; i++) begin
            send(v1[i], i == 5, 0, ok);
            check("t1_accept", ok, 1);
        end
        @(negedge clock);
        check("t1_startvd", startvd, 1);
        check("t1_ndata",   Ndata,   3);
        check("t1_ready_low", in_ready, 0);
        tick();
        run_divider(ok);
        check("t1_done_seen", ok, 1);
        @(negedge clock);
        check("t1_done_pulse_end", done, 0);
        check("t1_ready_idle",     in_ready, 1);
        tick();
        check("t1_nwrites", nwr - base, 6);
        check_writes("t1", base, 6, 0, v1);
        check("t1_nstart", n_start - s0, 1);
        check("t1_ndone",  n_done - d0,  1);
        check("t1_err",    err, 0);

        // Same data with random input gaps
        base = nwr; s0 = n_start;
        for (int i = 0; i < 6; i++) begin
            send(v1[i], i == 5, int'($urandom_range(0, 3)), ok);
            check("t2_accept", ok, 1);
        end
        @(negedge clock);
        check("t2_startvd", startvd, 1);
        check("t2_ndata",   Ndata,   3);
        tick();
        run_divider(ok);
        check("t2_done_seen", ok, 1);
        check("t2_nwrites", nwr - base, 6);
        check_writes("t2", base, 6, 0, v1);
        check("t2_wen_without_accept", bad_wen, 0);

        // busyvd glitch while idle is ignored
        s0 = n_start; d0 = n_done;
        busyvd = 1'b1;
        tick();
        busyvd = 1'b0;
        tick();
        @(negedge clock);
        check("glitch_ready", in_ready, 1);
        check("glitch_no_done", n_done - d0, 0);
        check("glitch_no_start", n_start - s0, 0);
        tick();

        // Odd word count: in_last on an X word
        base = nwr; s0 = n_start;
        for (int i = 0; i < 5; i++) begin
            send(v3[i], i == 4, 0, ok);
            check("t3_accept", ok, 1);
        end
        @(negedge clock);
        check("t3_startvd", startvd, 1);
        check("t3_ndata",   Ndata,   2);
        check("t3_err",     err,     1);
        tick();
        run_divider(ok);
        check("t3_done_seen", ok, 1);
        check("t3_nwrites", nwr - base, 5);
        check_writes("t3", base, 5, 0, v3);
        check("t3_nstart", n_start - s0, 1);

        // Single X word with in_last: no divider run
        base = nwr; s0 = n_start;
        send(55, 1'b1, 0, ok);
        check("t4_accept", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 2 && !ok; i++) begin
            @(negedge clock);
            ok = done;
            tick();
        end
        check("t4_done_within_2", ok, 1);
        check("t4_err", err, 1);
        repeat (3) tick();
        check("t4_no_start", n_start - s0, 0);
        check("t4_nwrites", nwr - base, 1);
        check("t4_addr", wr_addr[base], 0);
        check("t4_data", wr_data[base], 55);

        // Overflow at MAXN=4 pairs
        base = nwr; s0 = n_start; d0 = n_done;
        for (int i = 0; i < 8; i++) begin
            send(32'(200 + i), 1'b0, 0, ok);
            check("t5_accept", ok, 1);
            if (i == 0) begin
                @(negedge clock);
                check("t5_err_cleared", err, 0);
                tick();
            end
        end
        @(negedge clock);
        check("t5_ready_low", in_ready, 0);
        check("t5_startvd",   startvd,  1);
        check("t5_ndata",     Ndata,    4);
        check("t5_err",       err,      1);
        tick();
        in_valid = 1'b1;
        for (int i = 8; i < 12; i++) begin
            in_data = 32'(200 + i);
            tick();
        end
        in_valid = 1'b0;
        check("t5_nwrites", nwr - base, 8);
        check("t5_last_addr", wr_addr[base+7], 7);
        run_divider(ok);
        check("t5_done_seen", ok, 1);
        check("t5_nstart", n_start - s0, 1);
        check("t5_ndone",  n_done - d0,  1);

        // Reset while waiting for the divider
        send(3, 1'b0, 0, ok);
        send(1, 1'b1, 0, ok);
        @(negedge clock);
        check("t6_startvd", startvd, 1);
        tick();
        busyvd = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        d0 = n_done;
        tick();
        @(negedge clock);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_ndata", Ndata,    0);
        check("t6_rst_done",  done,     0);
        check("t6_rst_err",   err,      0);
        tick();
        busyvd = 1'b0;
        reset  = 1'b1;
        tick();
        @(negedge clock);
        check("t6_ready_back", in_ready, 1);
        tick();
        repeat (3) tick();
        check("t6_no_done", n_done - d0, 0);
        base = nwr;
        send(v6[0], 1'b0, 0, ok);
        send(v6[1], 1'b1, 0, ok);
        @(negedge clock);
        check("t6_ndata", Ndata, 1);
        tick();
        run_divider(ok);
        check("t6_done_seen", ok, 1);
        check("t6_nwrites", nwr - base, 2);
        check_writes("t6", base, 2, 0, v6);

        check("wen_without_accept", bad_wen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter RAM_SIZE, default 10, RAM address width (1024 words).
REQ-002 Parameter NBITS, default 32, data word width.
REQ-003 Parameter MAXN, default 256, maximum number of X/Y pairs per vector; must not exceed 2^(RAM_SIZE-1).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand word present on in_data.
REQ-007 in_data  input  NBITS  operand word; even-indexed words are X, odd-indexed words are Y.
REQ-008 in_last  input  1  qualifies the final word of a vector.
REQ-009 in_ready  output  1  loader accepts a word when in_valid and in_ready are both high.
REQ-010 Addr  output  RAM_SIZE  RAM write address.
REQ-011 Wdata  output  NBITS  RAM write data.
REQ-012 Wenable  output  1  RAM write strobe.
REQ-013 Ndata  output  RAM_SIZE  pair count handed to the vector divider.
REQ-014 startvd  output  1  one-cycle start pulse to the vector divider.
REQ-015 busyvd  input  1  divider busy flag.
REQ-016 done  output  1  one-cycle pulse when the divider has finished the vector.
REQ-017 err  output  1  sticky per-vector error flag, covering an odd word count or an overflow.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE and FINISH.
REQ-019 in_ready SHALL be high only in IDLE and LOAD, and low in all other states.
REQ-020 IDLE: the first accepted word SHALL clear the word counter, the pair counter and err, and SHALL cause a transition to LOAD, or to the in_last handling of REQ-024/025 if in_last is set.
REQ-021 Word k of a vector, counting from 0, SHALL be written to Addr = k: X of pair p at 2p, Y of pair p at 2p+1.
REQ-022 Each write SHALL be registered: Addr, Wdata and Wenable are asserted the cycle after acceptance, with Wenable high for exactly one cycle per word.
REQ-023 Each accepted Y word SHALL increment the pair count.
REQ-024 When in_last arrives on a Y word, the FSM SHALL move to KICK.
REQ-025 When in_last arrives on an X word, the FSM SHALL still write that word, set err, leave the unpaired X out of Ndata, and then:
- move to KICK if the pair count is greater than 0;
- otherwise move to FINISH with no startvd.
REQ-026 On overflow (the pair count reaches MAXN without in_last on that Y word), the FSM SHALL drop in_ready the next cycle, set err and move to KICK.
REQ-027 Words presented after an overflow SHALL not be accepted; the upstream source is responsible for them.
REQ-028 KICK SHALL hold Ndata at the pair count, pulse startvd for one cycle, and move to WAIT_BUSY.
REQ-029 Ndata SHALL be registered and stable from KICK until the next vector's first accepted word.
REQ-030 WAIT_BUSY SHALL move to WAIT_DONE on busyvd=1.
REQ-031 WAIT_DONE SHALL move to FINISH on busyvd=0.
REQ-032 FINISH SHALL pulse done for one cycle and then return to IDLE.
REQ-033 A busyvd glitch outside WAIT_BUSY and WAIT_DONE SHALL be ignored.
REQ-034 The pair counter SHALL be RAM_SIZE bits wide and SHALL never wrap, because overflow is caught at MAXN.

Reset
REQ-035 reset=0 at a clock edge SHALL force IDLE and clear the counters; registered outputs SHALL be low or zero from the following cycle: in_ready=0, Wenable=0, startvd=0, done=0, err=0, Addr=0, Wdata=0, Ndata=0.
REQ-036 in_ready SHALL be low while reset=0 and SHALL rise in the first cycle after reset is released.
REQ-037 A reset mid-load or mid-wait SHALL abort the vector with no done pulse; RAM contents are left as written.

Structure
REQ-038 The FSM state encoding and default parameter values SHALL reside in the shared vector_divide package, alongside the divider's constants.
REQ-039 vector_loader SHALL be a single module with no sub-modules; it instantiates beside vector_divider, sharing the RAM write port through an external mux.

Verification
REQ-040 Three pairs (100,5),(81,9),(7,2), with in_last on word 5 and no stalls -> Addr 0..5 written with 100,5,81,9,7,2; Ndata=3; one startvd; busyvd 1 for 10 cycles then 0 -> done pulses once; err=0.
REQ-041 Random in_valid gaps on the same data -> identical RAM writes; Wenable never fires without an accept.
REQ-042 Five words with in_last on word 4 (X) -> word 4 written at Addr 4; Ndata=2; err=1; startvd pulsed.
REQ-043 A single word with in_last (X, zero pairs) -> no startvd; done pulses within 2 cycles; err=1.
REQ-044 With MAXN=4, 12 words and no in_last -> 8 words accepted; in_ready low from the cycle after word 7; Ndata=4; err=1.
REQ-045 reset=0 while in WAIT_DONE -> IDLE next cycle; no done pulse; the next vector loads from Addr 0.
